// File: rtl/parallel_serial_pkg.sv
// Shared types and constants for the parallel-to-serial transmit stage.
package parallel_serial_pkg;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [7:0] IDLE_WORD_DEFAULT = 8'hBC;

    // Cycles needed to shift one word out; callers guard WIDTH % LANES == 0.
    function automatic int beats(input int width, input int lanes);
        return width / lanes;
    endfunction

endpackage

// File: rtl/ps_hold_reg.sv
// One-entry holding register: a word waiting for the next word boundary.
module ps_hold_reg
    import parallel_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             take,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
        end else if (take) begin
            full <= 1'b0;
        end else if (wr_en) begin
            full <= 1'b1;
        end
    end

    // NOTE: the payload is deliberately not reset; it is only consumed while full is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data <= wr_data;
        end
    end

endmodule

// File: rtl/parallel_serial_gen.sv
// Parametrised parallel-to-serial converter with idle insertion and a
// post-reset sync preamble; one word buffered ahead of the shifter.
module parallel_serial_gen
    import parallel_serial_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               LANES      = 1,
    parameter logic [WIDTH-1:0] IDLE_WORD  = WIDTH'(IDLE_WORD_DEFAULT),
    parameter bit               MSB_FIRST  = 1'b1,
    parameter int               SYNC_WORDS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_in,
    output logic [LANES-1:0] data_out,
    output logic             valid_out,
    output logic             word_start,
    output logic             synced
);

    localparam int BEATS = beats(WIDTH, LANES);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WC_W  = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [WC_W-1:0]  LAST_SYNC = WC_W'(SYNC_WORDS - 1);

    if (WIDTH % LANES != 0) begin : g_width_check
        $error("parallel_serial_gen: WIDTH must be a multiple of LANES");
    end
    if (SYNC_WORDS < 1) begin : g_sync_check
        $error("parallel_serial_gen: SYNC_WORDS must be at least 1");
    end

    state_t           state;
    logic             primed;
    logic [CNT_W-1:0] cnt;
    logic [WC_W-1:0]  word_cnt;
    logic [WIDTH-1:0] cur_word;
    logic             pend_full;
    logic [WIDTH-1:0] pend_data;
    logic             handshake;
    logic             at_wrap;
    logic             bypass;
    logic             pend_wr;
    logic             take;
    logic [WIDTH-1:0] load_word;
    logic             load_valid;

    assign ready_in  = synced & ~pend_full;
    assign handshake = valid_in & ready_in;
    assign at_wrap   = primed & (cnt == LAST_BEAT);
    assign bypass    = handshake & at_wrap;
    assign pend_wr   = handshake & ~at_wrap;
    assign take      = at_wrap & synced & pend_full;

    ps_hold_reg #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (pend_wr),
        .wr_data (data_in),
        .take    (take),
        .full    (pend_full),
        .data    (pend_data)
    );

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        load_word  = IDLE_WORD;
        load_valid = 1'b0;
        if (take) begin
            load_word  = pend_data;
            load_valid = 1'b1;
        end else if (bypass) begin
            load_word  = data_in;
            load_valid = 1'b1;
        end
    end

    function automatic logic [LANES-1:0] slice_of(input logic [WIDTH-1:0] w,
                                                  input logic [CNT_W-1:0] k);
        logic [WIDTH-1:0] s;
        if (MSB_FIRST) begin
            s = w << (int'(k) * LANES);
            return s[WIDTH-1 -: LANES];
        end else begin
            s = w >> (int'(k) * LANES);
            return s[LANES-1:0];
        end
    endfunction

    // The first cycle out of reset presents beat 0 of an idle word without advancing cnt.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking throughout so every flop samples pre-edge values.
        if (reset) begin
            state      <= SYNC;
            synced     <= 1'b0;
            primed     <= 1'b0;
            cnt        <= '0;
            word_cnt   <= '0;
            cur_word   <= IDLE_WORD;
            data_out   <= '0;
            valid_out  <= 1'b0;
            word_start <= 1'b0;
        end else if (!primed) begin
            primed     <= 1'b1;
            cur_word   <= IDLE_WORD;
            data_out   <= slice_of(IDLE_WORD, '0);
            valid_out  <= 1'b0;
            word_start <= 1'b1;
        end else if (at_wrap) begin
            cnt        <= '0;
            cur_word   <= load_word;
            valid_out  <= load_valid;
            data_out   <= slice_of(load_word, '0);
            word_start <= 1'b1;
            if (state == SYNC) begin
                word_cnt <= word_cnt + 1'b1;
                if (word_cnt == LAST_SYNC) begin
                    state  <= RUN;
                    synced <= 1'b1;
                end
            end
        end else begin
            cnt        <= cnt + 1'b1;
            data_out   <= slice_of(cur_word, cnt + 1'b1);
            word_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_parallel_serial_gen.sv
// Scoreboard bench: words are rebuilt from the serial stream and matched
// against the queue of accepted words, idle words against IDLE_WORD.
module tb_parallel_serial_gen;

    localparam int         BEATS      = 8;
    localparam int         SYNC_WORDS = 4;
    localparam logic [7:0] IDLE       = 8'hBC;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;

    logic       d0_valid_in = 1'b0;
    logic [7:0] d0_data_in = 8'h00;
    logic       d0_ready_in, d0_data_out, d0_valid_out, d0_word_start, d0_synced;

    logic       d1_valid_in = 1'b0;
    logic [7:0] d1_data_in = 8'h00;
    logic       d1_ready_in, d1_valid_out, d1_word_start, d1_synced;
    logic [1:0] d1_data_out;

    int   vectors = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   vstart[$];

    int         pos = -1;
    logic       in_word = 1'b0;
    logic       armed = 1'b0;
    logic       wvalid = 1'b0;
    logic [7:0] acc = 8'h00;
    int         nbeats = 0;
    int         wstart = 0;
    int         mon_lat = 0;
    exp_t       mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    parallel_serial_gen dut0 (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (d0_valid_in),
        .data_in    (d0_data_in),
        .ready_in   (d0_ready_in),
        .data_out   (d0_data_out),
        .valid_out  (d0_valid_out),
        .word_start (d0_word_start),
        .synced     (d0_synced)
    );

    parallel_serial_gen #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (d1_valid_in),
        .data_in    (d1_data_in),
        .ready_in   (d1_ready_in),
        .data_out   (d1_data_out),
        .valid_out  (d1_valid_out),
        .word_start (d1_word_start),
        .synced     (d1_synced)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: rebuild each MSB-first word from the bit stream.
    always @(negedge clk) begin
        if (reset) begin
            in_word = 1'b0;
            armed   = 1'b0;
            pos     = -1;
        end else if (d0_word_start) begin
            if (in_word) check("word_length", nbeats, BEATS);
            in_word = 1'b1;
            armed   = 1'b1;
            nbeats  = 1;
            pos     = 0;
            acc     = {7'b0, d0_data_out};
            wvalid  = d0_valid_out;
            wstart  = cyc;
        end else if (in_word) begin
            check("valid_out_const", d0_valid_out, wvalid);
            acc    = {acc[6:0], d0_data_out};
            nbeats = nbeats + 1;
            pos    = nbeats - 1;
            if (nbeats == BEATS) begin
                in_word = 1'b0;
                if (wvalid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_data_word", sb.size(), 1);
                    end else begin
                        mon_e   = sb.pop_front();
                        mon_lat = wstart - mon_e.cyc;
                        check("data_word", acc, mon_e.data);
                        check("latency_in_range", 32'(mon_lat >= 1 && mon_lat <= 2 * BEATS), 1);
                        vstart.push_back(wstart);
                    end
                end else begin
                    check("idle_word", acc, IDLE);
                end
            end
        end else if (armed) begin
            check("word_start_expected", d0_word_start, 1);
        end
    end

    task automatic send(input logic [7:0] w);
        int   n = 0;
        exp_t e;
        d0_valid_in = 1'b1;
        d0_data_in  = w;
        while (d0_ready_in !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 200), 1);
        if (n < 200) begin
            e.data = w;
            e.cyc  = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("drain", sb.size(), 0);
    endtask

    task automatic wait_last_beat();
        int n = 0;
        @(negedge clk);
        #1;
        while (pos != BEATS - 1 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("find_last_beat", pos, BEATS - 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic       early_ready;
        logic [1:0] lane_exp [4];
        lane_exp = '{2'b11, 2'b11, 2'b10, 2'b11};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data_out", d0_data_out, 0);
        check("rst_valid_out", d0_valid_out, 0);
        check("rst_word_start", d0_word_start, 0);
        check("rst_ready_in", d0_ready_in, 0);
        check("rst_synced", d0_synced, 0);
        check("rst_lane_data_out", d1_data_out, 0);
        check("rst_lane_synced", d1_synced, 0);

        // Word offered throughout the preamble must wait for synced.
        d0_valid_in = 1'b1;
        d0_data_in  = 8'h5A;
        reset       = 1'b0;
        n           = 0;
        early_ready = 1'b0;
        while (!d0_synced && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("first_word_start", d0_word_start, 1);
                check("first_bit", d0_data_out, IDLE[7]);
            end
            if (!d0_synced && d0_ready_in) early_ready = 1'b1;
        end
        check("sync_cycles", n, SYNC_WORDS * BEATS + 1);
        check("ready_during_sync", early_ready, 0);
        send(8'h5A);
        d0_valid_in = 1'b0;
        wait_drain();

        // Bypass: offered on the last beat, shown on the very next cycle.
        wait_last_beat();
        send(8'hAB);
        d0_valid_in = 1'b0;
        check("bypass_word_start", d0_word_start, 1);
        check("bypass_valid_out", d0_valid_out, 1);
        check("bypass_bit0", d0_data_out, 1);
        wait_drain();
        @(negedge clk);
        check("idle_resume_start", d0_word_start, 1);
        check("idle_resume_valid", d0_valid_out, 0);

        // Back-to-back stream with valid_in held high.
        vstart.delete();
        send(8'hAB);
        send(8'h56);
        send(8'h01);
        send(8'hAC);
        d0_valid_in = 1'b0;
        wait_drain();
        check("b2b_words", vstart.size(), 4);
        for (int i = 1; i < vstart.size(); i++) begin
            check("b2b_gap", vstart[i] - vstart[i-1], BEATS);
        end

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            send(8'($urandom));
            d0_valid_in = 1'b0;
        end
        wait_drain();

        // Reset on beat 3 with one word in flight and one pending.
        wait_last_beat();
        send(8'h3C);
        send(8'hC3);
        d0_valid_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        check("midrst_data_out", d0_data_out, 0);
        check("midrst_valid_out", d0_valid_out, 0);
        check("midrst_ready_in", d0_ready_in, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rel_word_start", d0_word_start, 1);
        check("rel_bit0", d0_data_out, IDLE[7]);
        check("rel_synced", d0_synced, 0);
        check("rel_valid_out", d0_valid_out, 0);
        n = 0;
        while (!d0_synced && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("resync", d0_synced, 1);
        repeat (3 * BEATS) @(negedge clk);

        // Two lanes, LSB-first.
        n = 0;
        while (!d1_synced && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("lane_synced", d1_synced, 1);
        d1_valid_in = 1'b1;
        d1_data_in  = 8'hEF;
        n = 0;
        while (d1_ready_in !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("lane_accept", d1_ready_in, 1);
        @(negedge clk);
        d1_valid_in = 1'b0;
        n = 0;
        while (!(d1_word_start && d1_valid_out) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("lane_word_found", d1_word_start & d1_valid_out, 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("lane_beat%0d", k), d1_data_out, lane_exp[k]);
            check($sformatf("lane_valid%0d", k), d1_valid_out, 1);
            @(negedge clk);
        end
        check("lane_idle_start", d1_word_start, 1);
        check("lane_idle_valid", d1_valid_out, 0);

        check("sb_empty_at_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
